// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// ---------------------------------------------------------------------------
// Central stall/flush controller for a 5-stage pipeline. It decodes the
// pipeline-register controls combinationally from the current FSM state and
// the stage inputs, so the registers act on them at the next rising edge.
//
// Hazard sources:
//   - load-use      : a load in EX feeds the instruction in ID -> one bubble
//   - branch / jump : a taken branch in EX or a jump in ID -> squash
//   - data memory   : a multi-cycle handshake with a timeout into a sticky
//                     error state
//
// Ports:
//   clk, reset         clock (rising edge), synchronous active-low reset
//   id_rs_addr/rt_addr source registers of the ID instruction
//   id_uses_rt         ID instruction reads rt
//   id_jump            jump decoded in ID
//   ex_mem_read        EX instruction is a load
//   ex_rd_addr         destination register of the EX instruction
//   ex_branch_taken    branch resolved taken in EX
//   mem_req/mem_ready  MEM stage access request / completion
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
//   ex_mem_hold, mem_wb_bubble   pipeline-register controls
//   mem_timeout_err    sticky memory timeout flag
//   stall_cnt          cycles with pc_write==0 (only with HAZARD_PERF_CNT_EN)
//   state_o            FSM state (RUN=0, MEM_WAIT=1, ERR=2)
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds the saturating stall_cnt
// output. Without it the port and counter do not exist.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_uses_rt,
    input  logic                  id_jump,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_hold,
    output logic                  mem_wb_bubble,
    output logic                  mem_timeout_err,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cnt,
`endif
    output logic [1:0]            state_o
);

    localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                err_q, err_d;

    logic load_use;
    logic mem_busy;
    logic freeze;
    logic use_decode;

    // A load only hazards against a real register; r0 is hard-wired zero.
    assign load_use = ex_mem_read && (ex_rd_addr != '0) &&
                      ((ex_rd_addr == id_rs_addr) ||
                       (id_uses_rt && (ex_rd_addr == id_rt_addr)));

    // A dropped request is treated as completion, so only req && !ready
    // keeps the memory busy.
    assign mem_busy = mem_req && !mem_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        freeze     = 1'b0;
        use_decode = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    use_decode = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    // Completion wins even on the last allowed cycle.
                    use_decode = 1'b1;
                    state_d    = RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            ERR: begin
                freeze = 1'b1;
            end
            default: begin
                // Illegal encoding: keep the pipeline flowing and recover.
                state_d = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            if (freeze) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_hold   = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (use_decode) begin
                if (ex_branch_taken) begin
                    // Squashes both wrong-path instructions; any load-use or
                    // jump in ID is on the wrong path and is ignored.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID for one cycle, inject one bubble.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (id_jump) begin
                    if_id_flush = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign mem_timeout_err = err_q;
    assign state_o         = state_q;

`ifdef HAZARD_PERF_CNT_EN
    // Counts PC-stalled cycles; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl with a behavioural model
// checked every cycle plus literal expectations on key scenarios.
module tb_pipeline_hazard_ctrl;

    localparam int AW   = 5;
    localparam int TMO  = 4;
    localparam int CW   = 32;

    localparam logic [6:0] IDLE = 7'b1101000;
    localparam logic [6:0] FRZ  = 7'b0000011;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs_addr, id_rt_addr, ex_rd_addr;
    logic          id_uses_rt, id_jump, ex_mem_read, ex_branch_taken;
    logic          mem_req, mem_ready;
    logic          pc_write, if_id_write, if_id_flush, id_ex_write;
    logic          id_ex_flush, ex_mem_hold, mem_wb_bubble, mem_timeout_err;
    logic [1:0]    state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble),
        .mem_timeout_err(mem_timeout_err),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    int     m_state = 0;   // 0 run, 1 waiting on memory, 2 error
    int     m_dwell = 0;   // memory-wait cycles already spent
    bit     m_err   = 1'b0;
    longint m_stall = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, hold, bubble}
    function automatic logic [6:0] model_ctrl();
        if (!reset)                return IDLE;
        if (m_state == 2)          return FRZ;
        if (mem_req && !mem_ready) return FRZ;
        if (ex_branch_taken)       return 7'b1111100;
        if (ex_mem_read && ex_rd_addr != 0 &&
            (ex_rd_addr == id_rs_addr || (id_uses_rt && ex_rd_addr == id_rt_addr)))
                                   return 7'b0001100;
        if (id_jump)               return 7'b1111000;
        return IDLE;
    endfunction

    always @(posedge clk) begin
        logic [6:0] c;
        c = model_ctrl();
        if (!reset) begin
            m_state = 0; m_dwell = 0; m_err = 1'b0; m_stall = 0;
        end else begin
            if (!c[6] && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (m_state == 0) begin
                if (mem_req && !mem_ready) begin m_state = 1; m_dwell = 0; end
            end else if (m_state == 1) begin
                if (!(mem_req && !mem_ready)) m_state = 0;
                else if (m_dwell + 1 >= TMO) begin m_state = 2; m_err = 1'b1; end
                else m_dwell++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [6:0] a, e;
            a = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                 ex_mem_hold, mem_wb_bubble};
            e = model_ctrl();
            n_chk++;
            if (a === e && state_o === 2'(m_state) && mem_timeout_err === m_err
`ifdef HAZARD_PERF_CNT_EN
                && stall_cnt === CW'(m_stall)
`endif
               ) n_pass++;
            else
                $display("FAIL model t=%0t ctrl=%b/%b state=%0d/%0d err=%0b/%0b",
                         $time, a, e, state_o, m_state, mem_timeout_err, m_err);
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    endtask

    task automatic clr();
        id_rs_addr = '0; id_rt_addr = '0; id_uses_rt = 1'b0; id_jump = 1'b0;
        ex_mem_read = 1'b0; ex_rd_addr = '0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic adv();    @(posedge clk); #2; endtask
    task automatic settle(); @(negedge clk); #1; endtask

    function automatic logic [6:0] ctl();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                ex_mem_hold, mem_wb_bubble};
    endfunction

    task automatic mem_busy(); clr(); mem_req = 1'b1; mem_ready = 1'b0; endtask

    task automatic do_reset();
        adv(); clr(); reset = 1'b0; settle();
        adv(); reset = 1'b1; settle();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b0; clr();
        // Reset with hazardous inputs: controls must stay idle.
        mem_req = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd3; id_rs_addr = 5'd3;
        adv(); chk_en = 1'b1; settle();
        lit("reset_idle", 32'(ctl()), 32'(IDLE));
        adv(); reset = 1'b1; clr(); settle();
        lit("reset_state", 32'(state_o), 0);
        lit("reset_err", 32'(mem_timeout_err), 0);
`ifdef HAZARD_PERF_CNT_EN
        lit("reset_stall_cnt", stall_cnt, 0);
`endif

        // Load-use on rs: one bubble, then idle.
        adv(); ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs_addr = 5'd5; settle();
        lit("load_use", 32'(ctl()), 32'(7'b0001100));
        adv(); clr(); settle();
        lit("after_load_use", 32'(ctl()), 32'(IDLE));

        // r0 destination and unused rt never stall.
        adv(); ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs_addr = 5'd0; settle();
        lit("rd_zero", 32'(pc_write), 1);
        adv(); clr(); ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rt_addr = 5'd7; id_rs_addr = 5'd1; settle();
        lit("rt_unused", 32'(pc_write), 1);
        adv(); id_uses_rt = 1'b1; settle();
        lit("rt_used", 32'(ctl()), 32'(7'b0001100));

        // Branch squashes a simultaneous load-use and jump.
        adv(); clr(); ex_mem_read = 1'b1; ex_rd_addr = 5'd9; id_rs_addr = 5'd9;
        ex_branch_taken = 1'b1; id_jump = 1'b1; settle();
        lit("branch_over_lu", 32'(ctl()), 32'(7'b1111100));
        adv(); clr(); id_jump = 1'b1; settle();
        lit("jump", 32'(ctl()), 32'(7'b1111000));

        // Memory wait: 3 busy cycles then ready.
        do_reset();
`ifdef HAZARD_PERF_CNT_EN
        lit("stall_cnt_zero", stall_cnt, 0);
`endif
        for (int i = 1; i <= 3; i++) begin
            adv(); mem_busy(); settle();
            lit($sformatf("memwait_frz%0d", i), 32'(ctl()), 32'(FRZ));
            lit($sformatf("memwait_st%0d", i), 32'(state_o), (i == 1) ? 0 : 1);
        end
        adv(); mem_ready = 1'b1; settle();
        lit("memwait_release", 32'(ctl()), 32'(IDLE));
        lit("memwait_release_st", 32'(state_o), 1);
        adv(); clr(); settle();
        lit("memwait_done_st", 32'(state_o), 0);
`ifdef HAZARD_PERF_CNT_EN
        lit("stall_cnt_three", stall_cnt, 3);
`endif

        // Request dropped while waiting counts as completion.
        adv(); mem_busy(); settle();
        adv(); clr(); settle();
        lit("req_drop_idle", 32'(ctl()), 32'(IDLE));
        lit("req_drop_st", 32'(state_o), 1);
        adv(); settle();
        lit("req_drop_run", 32'(state_o), 0);

        // Ready on the last permitted wait cycle returns to RUN.
        for (int i = 0; i < TMO; i++) begin adv(); mem_busy(); settle(); end
        adv(); mem_ready = 1'b1; settle();
        lit("tmo_edge_ready", 32'(ctl()), 32'(IDLE));
        adv(); clr(); settle();
        lit("tmo_edge_run", 32'(state_o), 0);
        lit("tmo_edge_noerr", 32'(mem_timeout_err), 0);

        // Timeout: 1 RUN + TMO wait cycles, then sticky ERR.
        for (int i = 0; i <= TMO; i++) begin adv(); mem_busy(); settle(); end
        lit("tmo_last_wait", 32'(state_o), 1);
        adv(); settle();
        lit("tmo_err_state", 32'(state_o), 2);
        lit("tmo_err_flag", 32'(mem_timeout_err), 1);
        adv(); clr(); mem_ready = 1'b1; settle();
        lit("err_sticky", 32'(state_o), 2);
        lit("err_frz", 32'(ctl()), 32'(FRZ));
        adv(); reset = 1'b0; settle();
        lit("err_reset_idle", 32'(ctl()), 32'(IDLE));
        adv(); reset = 1'b1; settle();
        lit("err_cleared_st", 32'(state_o), 0);
        lit("err_cleared_flag", 32'(mem_timeout_err), 0);

        // Reset in the middle of a wait.
        adv(); mem_busy(); settle();
        adv(); settle();
        lit("midwait_st", 32'(state_o), 1);
        adv(); reset = 1'b0; settle();
        adv(); reset = 1'b1; clr(); settle();
        lit("midwait_reset_st", 32'(state_o), 0);
        lit("midwait_reset_idle", 32'(ctl()), 32'(IDLE));

        adv(); settle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It generates the write-enable, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Sources handled: load-use hazards, taken branches and jumps, and a multi-cycle data-memory handshake with timeout. Controls are decoded in the same cycle from current state and stage inputs, so the pipeline registers act on them at the next clock edge.

Parameters:
REG_ADDR_W, 5, width of register-file addresses
MEM_TIMEOUT, 16, max MEM_WAIT cycles before error (>=2)
CNT_W, 32, width of optional stall counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
id_rs_addr  in  REG_ADDR_W  rs of instruction in ID
id_rt_addr  in  REG_ADDR_W  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
id_jump  in  1  jump decoded in ID
ex_mem_read  in  1  EX instruction is a load
ex_rd_addr  in  REG_ADDR_W  destination of EX instruction
ex_branch_taken  in  1  branch resolved taken in EX
mem_req  in  1  MEM stage has an active load/store
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_write  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX clear to bubble
ex_mem_hold  out  1  EX/MEM keeps current contents
mem_wb_bubble  out  1  MEM/WB loads zeroed control (reg_write=0)
mem_timeout_err  out  1  sticky memory timeout flag
state_o  out  2  current FSM state (RUN=0, MEM_WAIT=1, ERR=2)

Behaviour:
- Idle control set: pc_write=1, if_id_write=1, id_ex_write=1; all other controls 0.
- Freeze set: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_hold=1, mem_wb_bubble=1, flushes=0.
- reset==0 at a clock edge: state<=RUN, wait_cnt<=0, mem_timeout_err<=0. While reset==0, outputs equal the idle control set regardless of inputs.
- load_use = ex_mem_read && ex_rd_addr!=0 && (ex_rd_addr==id_rs_addr || (id_uses_rt && ex_rd_addr==id_rt_addr)).
- Normal decode, first match wins:
  1. mem_req && !mem_ready: freeze set.
  2. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1. Branch squashes the load-use and jump cases.
  3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble per hazard.
  4. id_jump: if_id_flush=1.
  5. Otherwise: idle control set.
- RUN: outputs follow normal decode. If mem_req && !mem_ready: next state MEM_WAIT, wait_cnt<=0.
- MEM_WAIT:
  - mem_ready=1: outputs follow normal decode with case 1 ignored; next state RUN.
  - mem_ready=0: freeze set, wait_cnt++. When wait_cnt==MEM_TIMEOUT-1, next state ERR.
  - mem_ready on the timeout cycle wins, so the transition is to RUN.
  - Total MEM_WAIT dwell is at most MEM_TIMEOUT cycles.
- ERR: freeze set every cycle, mem_timeout_err=1. Leaves only via reset.
- mem_req dropping while in MEM_WAIT is treated as mem_ready=1.
- wait_cnt width is clog2(MEM_TIMEOUT) and never wraps.
- state_o encodes 3 as illegal; the FSM recovers to RUN on the next clock.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds output stall_cnt[CNT_W-1:0], reset to 0. It increments on every clock where reset==1 and pc_write==0, and saturates at all-ones.
- Undefined: the port and counter are absent; all other behaviour is unchanged.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs_addr=5 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle (ex_mem_read=0) idle set.
- rd=0 / unused rt: ex_rd_addr=0 with rs=0 -> no stall. ex_rd_addr=7, id_rt_addr=7, id_uses_rt=0 -> no stall.
- Branch over load-use: ex_branch_taken=1 together with the load-use match -> if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> freeze set for 3 cycles, state_o=1 for cycles 2-4; release cycle shows idle set; state_o=0 after.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready never -> ERR after 1 RUN + 4 MEM_WAIT cycles, mem_timeout_err=1 sticky. Then reset=0 for one edge -> state_o=0, err=0.
- Reset mid-wait: reset=0 during MEM_WAIT -> next cycle state_o=0, outputs idle. With HAZARD_PERF_CNT_EN, stall_cnt=0 after reset and equals 3 after the memory-wait scenario.
